// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Edge-triggered send request, registered serial output.
module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Send,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx
);

    localparam int unsigned     CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic            STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic            HAS_PARITY = (PARITY != 0);
    localparam logic            ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_cnt;
    logic               stop_cnt;
    logic [7:0]         shift;
    logic [7:0]         shift_nxt;
    logic               parity_bit;
    logic               send_q;
    logic               req;
    logic               bit_end;
    logic               tx_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    // A request is a rising edge of the send level
    assign req     = Tx_Send & ~send_q;
    assign bit_end = (baud_cnt == BAUD_LAST);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; completion edge lands in IDLE so a request there is not seen
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req) state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = S_DATA;
            S_DATA:   if (bit_end && (bit_cnt == 3'd7)) state_nxt = HAS_PARITY ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP:   if (bit_end && (stop_cnt == STOP_LAST)) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next shift-register contents: load on accept, shift right at data-bit boundaries
    always_comb begin
        shift_nxt = shift;
        if ((state == S_IDLE) && req) begin
            shift_nxt = Tx_Data;
        end else if ((state == S_DATA) && bit_end) begin
            shift_nxt = {1'b0, shift[7:1]};
        end
    end

    // Output decode from the next state so Tx/Tx_Busy change on the same edge as the state
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state == S_STOP) && (state_nxt == S_IDLE);
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shift_nxt[0];
            S_PARITY: tx_nxt = parity_bit;
            default:  tx_nxt = 1'b1;
        endcase
    end

    // Datapath registers, counters and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift      <= '0;
            parity_bit <= 1'b0;
            send_q     <= 1'b1;
            Tx         <= 1'b1;
            Tx_Busy    <= 1'b0;
            Tx_Done    <= 1'b0;
        end else begin
            send_q  <= Tx_Send;
            shift   <= shift_nxt;
            Tx      <= tx_nxt;
            Tx_Busy <= busy_nxt;
            Tx_Done <= done_nxt;

            if ((state == S_IDLE) && req) begin
                parity_bit <= (^Tx_Data) ^ ODD_PARITY;
            end

            if ((state == S_IDLE) || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state != S_STOP) begin
                stop_cnt <= 1'b0;
            end else if (bit_end) begin
                stop_cnt <= ~stop_cnt;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: five parameter sets, table-driven frames with a
// byte scoreboard, plus hand-written sequences for hold, abort and back-to-back cases.
module tb_uart_tx_framer;

    logic       clk;
    logic       reset;
    logic [7:0] data [5];
    logic [4:0] send;
    logic [4:0] busy;
    logic [4:0] done;
    logic [4:0] tx;

    int n_tests;
    int n_fail;

    logic       sb [$];
    logic [7:0] sb_q [$];
    logic       cap [$];
    int         cap_lat;
    int         cap_done_in;
    logic       cap_done_end;

    typedef struct {
        int          cfg;
        logic [7:0]  data;
        int          len;
        logic [11:0] frame;
    } vec_t;

    vec_t vecs [11];

    // cfg0: 4 clk, no parity, 1 stop   cfg1: even parity   cfg2: odd parity
    // cfg3: 2 stop bits                cfg4: 434 clk/bit
    uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_cfg0 (
        .Clk(clk), .Reset(reset), .Tx_Data(data[0]), .Tx_Send(send[0]),
        .Tx_Busy(busy[0]), .Tx_Done(done[0]), .Tx(tx[0]));
    uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_cfg1 (
        .Clk(clk), .Reset(reset), .Tx_Data(data[1]), .Tx_Send(send[1]),
        .Tx_Busy(busy[1]), .Tx_Done(done[1]), .Tx(tx[1]));
    uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_cfg2 (
        .Clk(clk), .Reset(reset), .Tx_Data(data[2]), .Tx_Send(send[2]),
        .Tx_Busy(busy[2]), .Tx_Done(done[2]), .Tx(tx[2]));
    uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_cfg3 (
        .Clk(clk), .Reset(reset), .Tx_Data(data[3]), .Tx_Send(send[3]),
        .Tx_Busy(busy[3]), .Tx_Done(done[3]), .Tx(tx[3]));
    uart_tx_framer #(.CLKS_PER_BIT(434), .PARITY(0), .STOP_BITS(1)) u_cfg4 (
        .Clk(clk), .Reset(reset), .Tx_Data(data[4]), .Tx_Send(send[4]),
        .Tx_Busy(busy[4]), .Tx_Done(done[4]), .Tx(tx[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb_of(input int k);
        return (k == 4) ? 434 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise a send request and record the expected byte
    task automatic send_start(input int k, input logic [7:0] b);
        data[k] = b;
        send[k] = 1'b1;
        sb_q.push_back(b);
    endtask

    // Sample Tx on every falling edge while busy.
    // mode 0: drop send after accept; 1: hold send; 2: toggle send and change data mid-frame;
    // 3: drop send, then raise it again in the last busy cycle
    task automatic capture(input int k, input int mode, input int exp_len);
        int guard;
        int j;
        cap.delete();
        cap_lat     = 0;
        cap_done_in = 0;
        do begin
            @(negedge clk);
            cap_lat++;
        end while (!busy[k] && cap_lat < 8);
        guard = 0;
        while (busy[k] && guard < 10000) begin
            cap.push_back(tx[k]);
            if (done[k]) cap_done_in++;
            j = cap.size() - 1;
            case (mode)
                0: if (j == 0) send[k] = 1'b0;
                2: begin
                    if (j == 0)  send[k] = 1'b0;
                    if (j == 12) begin send[k] = 1'b1; data[k] = 8'hAA; end
                    if (j == 14) send[k] = 1'b0;
                end
                3: begin
                    if (j == 0) send[k] = 1'b0;
                    if (j == exp_len - 1) send[k] = 1'b1;
                end
                default: ;
            endcase
            @(negedge clk);
            guard++;
        end
        cap_done_end = done[k];
    endtask

    // Compare the captured frame against the expected line pattern and the scoreboard
    task automatic check_frame(input int k, input int exp_len, input logic [11:0] exp_frame);
        int         cpb;
        int         mism;
        int         first_bad;
        logic       e;
        logic [7:0] dec;
        logic [31:0] exp_b;
        cpb       = cpb_of(k);
        mism      = 0;
        first_bad = -1;
        chk("start_latency", 32'(cap_lat), 32'd1);
        chk("busy_len", 32'(cap.size()), 32'(exp_len));
        for (int j = 0; j < cap.size(); j++) begin
            e = ((j / cpb) < 12) ? exp_frame[j / cpb] : 1'b1;
            if (cap[j] !== e) begin
                mism++;
                if (first_bad < 0) first_bad = j;
            end
        end
        if (mism != 0) $display("  first bad sample at cycle %0d of frame", first_bad);
        chk("frame_bits", 32'(mism), 32'd0);
        dec = 8'hxx;
        if (cap.size() >= 9 * cpb) begin
            for (int i = 0; i < 8; i++) dec[i] = cap[(i + 1) * cpb + cpb / 2];
        end
        exp_b = 32'hDEAD;
        if (sb_q.size() != 0) exp_b = 32'(sb_q.pop_front());
        chk("sb_data", 32'(dec), exp_b);
        chk("done_in_frame", 32'(cap_done_in), 32'd0);
        chk("done_at_end", 32'(cap_done_end), 32'd1);
    endtask

    // Run a frame to completion, then confirm the done pulse is one cycle and the line idles
    task automatic run_frame(input int k, input logic [7:0] b, input int len, input logic [11:0] fr);
        send_start(k, b);
        capture(k, 0, len);
        check_frame(k, len, fr);
        @(negedge clk);
        chk("done_width", 32'(done[k]), 32'd0);
        chk("idle_tx", 32'(tx[k]), 32'd1);
    endtask

    initial begin
        int cnt;
        int cnt2;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        send    = '0;
        for (int k = 0; k < 5; k++) data[k] = 8'h00;

        vecs[0]  = '{cfg: 0, data: 8'h41, len: 40,   frame: 12'h282};
        vecs[1]  = '{cfg: 1, data: 8'h41, len: 44,   frame: 12'h482};
        vecs[2]  = '{cfg: 2, data: 8'h41, len: 44,   frame: 12'h682};
        vecs[3]  = '{cfg: 3, data: 8'hFF, len: 44,   frame: 12'h7FE};
        vecs[4]  = '{cfg: 0, data: 8'h00, len: 40,   frame: 12'h200};
        vecs[5]  = '{cfg: 1, data: 8'h03, len: 44,   frame: 12'h406};
        vecs[6]  = '{cfg: 2, data: 8'h07, len: 44,   frame: 12'h40E};
        vecs[7]  = '{cfg: 1, data: 8'h07, len: 44,   frame: 12'h60E};
        vecs[8]  = '{cfg: 3, data: 8'h55, len: 44,   frame: 12'h6AA};
        vecs[9]  = '{cfg: 4, data: 8'h00, len: 4340, frame: 12'h200};
        vecs[10] = '{cfg: 4, data: 8'h55, len: 4340, frame: 12'h2AA};

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("reset_tx", 32'(tx[k]), 32'd1);
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_done", 32'(done[k]), 32'd0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 11; v++) begin
            run_frame(vecs[v].cfg, vecs[v].data, vecs[v].len, vecs[v].frame);
        end

        // Send held high for ~100 cycles: exactly one frame
        send_start(0, 8'h55);
        capture(0, 1, 40);
        check_frame(0, 40, 12'h2AA);
        cnt  = 0;
        cnt2 = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy[0]) cnt++;
            if (!tx[0]) cnt2++;
        end
        chk("hold_no_retrigger", 32'(cnt), 32'd0);
        chk("hold_tx_idle", 32'(cnt2), 32'd0);
        send[0] = 1'b0;
        @(negedge clk);

        // Toggle send and change data mid-frame: frame still carries 0x55
        send_start(0, 8'h55);
        capture(0, 2, 40);
        check_frame(0, 40, 12'h2AA);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy[0]) cnt++;
        end
        chk("midframe_no_second", 32'(cnt), 32'd0);

        // Request edge on the completion cycle is not accepted
        send_start(0, 8'h0F);
        capture(0, 3, 40);
        check_frame(0, 40, 12'h21E);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy[0]) cnt++;
        end
        chk("complete_edge_reject", 32'(cnt), 32'd0);
        send[0] = 1'b0;
        @(negedge clk);

        // New edge one cycle after Tx_Busy falls starts the next frame with a 1-cycle gap
        send_start(0, 8'hC3);
        capture(0, 0, 40);
        check_frame(0, 40, 12'h386);
        send_start(0, 8'h3C);
        capture(0, 0, 40);
        check_frame(0, 40, 12'h278);
        @(negedge clk);

        // Reset during data bit 3 aborts asynchronously; held send does not start a frame
        data[0] = 8'h41;
        send[0] = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!busy[0] && cnt < 8);
        chk("abort_started", 32'(busy[0]), 32'd1);
        for (int j = 0; j < 17; j++) begin
            if (j == 0) send[0] = 1'b0;
            @(negedge clk);
        end
        chk("abort_pre_tx", 32'(tx[0]), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("abort_tx_async", 32'(tx[0]), 32'd1);
        chk("abort_busy_async", 32'(busy[0]), 32'd0);
        send[0] = 1'b1;
        cnt = done[0] ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (done[0]) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy[0] || !tx[0]) cnt++;
        end
        chk("held_send_after_reset", 32'(cnt), 32'd0);
        send[0] = 1'b0;
        @(negedge clk);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
